proc_data_ram: RTL and testbench

Single-port-style data memory that sits directly downstream of the simple processor's data bus and serves its load/store traffic. Commits processor stores, returns registered read data for loads, and offers a host preload port with a valid/ready handshake. After reset it sweeps the whole array to zero before accepting traffic.

---
 rtl/proc_data_ram.sv | 114 +++++++++++
 tb/tb_proc_data_ram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_data_ram.sv
// Data memory behind the processor data bus: filtered stores, registered loads,
// host preload port, and a zeroing sweep after every reset.
module proc_data_ram #(
    parameter int width    = 32,
    parameter int addrsize = 8,
    parameter int memsize  = 1 << addrsize
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                proc_we,
    input  logic [addrsize-1:0] proc_addr,
    input  logic [width-1:0]    proc_wdata,
    output logic [width-1:0]    proc_rdata,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [addrsize-1:0] ld_addr,
    input  logic [width-1:0]    ld_data,
    output logic                busy,
    output logic [15:0]         wr_count
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [addrsize-1:0] last_ptr = addrsize'(memsize - 1);

    state_t              state;
    logic [addrsize-1:0] ptr;
    logic [addrsize-1:0] last_addr;
    logic [width-1:0]    last_data;
    logic                prev_we;

    logic [width-1:0]    mem [memsize];

    logic                proc_commit;
    logic                host_xfer;
    logic                mem_we;
    logic [addrsize-1:0] mem_waddr;
    logic [width-1:0]    mem_wdata;

    // The processor holds proc_we high between stores, so only a new or changed store commits.
    assign proc_commit = (state == IDLE) && proc_we &&
                         (!prev_we || (proc_addr != last_addr) || (proc_wdata != last_data));
    assign ld_ready    = (state == IDLE) && !proc_commit;
    assign host_xfer   = ld_valid && ld_ready;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (proc_commit) begin
            mem_we    = 1'b1;
            mem_waddr = proc_addr;
            mem_wdata = proc_wdata;
        end else if (host_xfer) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
        end
    end

    // Array itself is never reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= CLEAR;
            ptr        <= '0;
            busy       <= 1'b1;
            prev_we    <= 1'b1;
            last_addr  <= '0;
            last_data  <= '0;
            wr_count   <= '0;
            proc_rdata <= '0;
        end else begin
            prev_we <= proc_we;
            case (state)
                CLEAR: begin
                    proc_rdata <= '0;
                    ptr        <= ptr + addrsize'(1);
                    if (ptr == last_ptr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    // Read-first: a same-edge host write to this address is not visible yet.
                    if (!proc_we) begin
                        proc_rdata <= mem[proc_addr];
                    end
                    if (proc_commit) begin
                        last_addr <= proc_addr;
                        last_data <= proc_wdata;
                        if (wr_count != 16'hFFFF) begin
                            wr_count <= wr_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_data_ram.sv
// Bench for proc_data_ram: array-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_proc_data_ram;

    localparam int W = 32;
    localparam int A = 8;
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         proc_we = 1'b1;
    logic [A-1:0] proc_addr = '0;
    logic [W-1:0] proc_wdata = '0;
    logic [W-1:0] proc_rdata;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [A-1:0] ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    logic         busy;
    logic [15:0]  wr_count;

    int compared   = 0;
    int mismatched = 0;

    proc_data_ram #(.width(W), .addrsize(A), .memsize(N)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .proc_we    (proc_we),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: whole memory as an array, clear as a countdown of remaining edges.
    logic [W-1:0] m_mem [N];
    int           m_clear_left = N;
    int           m_count      = 0;
    logic [W-1:0] m_rdata      = '0;
    logic         m_prev_we    = 1'b1;
    logic [A-1:0] m_last_addr  = '0;
    logic [W-1:0] m_last_data  = '0;
    bit           m_commit;

    function automatic bit model_commit();
        return (m_clear_left == 0) && proc_we &&
               (!m_prev_we || (proc_addr != m_last_addr) || (proc_wdata != m_last_data));
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_clear_left = N;
            m_count      = 0;
            m_rdata      = '0;
            m_prev_we    = 1'b1;
            m_last_addr  = '0;
            m_last_data  = '0;
        end else if (m_clear_left > 0) begin
            m_mem[N - m_clear_left] = '0;
            m_clear_left = m_clear_left - 1;
            m_rdata      = '0;
            m_prev_we    = proc_we;
        end else begin
            m_commit = model_commit();
            if (!proc_we) m_rdata = m_mem[proc_addr];
            if (m_commit) begin
                m_mem[proc_addr] = proc_wdata;
                m_last_addr = proc_addr;
                m_last_data = proc_wdata;
                if (m_count < 65535) m_count = m_count + 1;
            end else if (ld_valid) begin
                m_mem[ld_addr] = ld_data;
            end
            m_prev_we = proc_we;
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(m_clear_left > 0));
        checkOutput("ld_ready", 32'(ld_ready), 32'((m_clear_left == 0) && !model_commit()));
        checkOutput("proc_rdata", proc_rdata, m_rdata);
        checkOutput("wr_count", 32'(wr_count), 32'(m_count));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [A-1:0] addr, input logic [W-1:0] wdata,
                                 input logic lv, input logic [A-1:0] laddr, input logic [W-1:0] ldata);
        proc_we    = we;
        proc_addr  = addr;
        proc_wdata = wdata;
        ld_valid   = lv;
        ld_addr    = laddr;
        ld_data    = ldata;
    endtask

    task automatic waitClear(input string name);
        int  cnt  = 0;
        bit  done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!busy) done = 1;
        end
        checkOutput(name, 32'(cnt), 32'd256);
    endtask

    task automatic checkReset(input string tag);
        #1;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_wr_count"}, 32'(wr_count), 32'd0);
        checkOutput({tag, "_rdata"}, proc_rdata, 32'd0);
        checkOutput({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    endtask

    task automatic readCheck(input string name, input logic [A-1:0] addr, input logic [W-1:0] expected);
        applyStimulus(1'b0, addr, '0, 1'b0, '0, '0);
        step(1);
        checkOutput(name, proc_rdata, expected);
    endtask

    initial begin
        step(3);
        checkReset("por");
        nrst = 1'b1;
        waitClear("clear_len");
        readCheck("clr_0x00", 8'h00, 32'h0);
        readCheck("clr_0x7f", 8'h7F, 32'h0);
        readCheck("clr_0xff", 8'hFF, 32'h0);

        // Held store commits once only
        applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, '0, '0);
        step(5);
        checkOutput("hold_count", 32'(wr_count), 32'd1);
        checkOutput("model_count", 32'(m_count), 32'd1);
        readCheck("store_0x10", 8'h10, 32'hDEADBEEF);
        applyStimulus(1'b1, 8'h10, 32'h1, 1'b0, '0, '0);
        step(3);
        checkOutput("change_count", 32'(wr_count), 32'd2);

        // Load latency and hold while proc_we=1
        readCheck("load_lat", 8'h10, 32'h1);
        applyStimulus(1'b1, 8'h30, 32'h77, 1'b0, '0, '0);
        step(1);
        checkOutput("rdata_hold", proc_rdata, 32'h1);
        checkOutput("hold_store_count", 32'(wr_count), 32'd3);

        // Host request colliding with a new processor store
        applyStimulus(1'b1, 8'h40, 32'h55, 1'b1, 8'h20, 32'hA5A5A5A5);
        #1;
        checkOutput("arb_ready_lo", 32'(ld_ready), 32'd0);
        step(1);
        checkOutput("arb_ready_hi", 32'(ld_ready), 32'd1);
        step(1);
        readCheck("preload_0x20", 8'h20, 32'hA5A5A5A5);
        checkOutput("arb_count", 32'(wr_count), 32'd4);

        // Read-first on same-address host write
        applyStimulus(1'b0, 8'h20, '0, 1'b1, 8'h20, 32'h12345678);
        step(1);
        checkOutput("read_first_old", proc_rdata, 32'hA5A5A5A5);
        readCheck("read_first_new", 8'h20, 32'h12345678);

        // Full-rate preload burst
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, '0, 1'b1, 8'(8'h50 + i), 32'(32'h1000 + i));
            step(1);
        end
        readCheck("burst_0x53", 8'h53, 32'h1003);
        readCheck("burst_0x57", 8'h57, 32'h1007);

        // Reset mid-traffic after preloading 0x20
        applyStimulus(1'b1, 8'h00, '0, 1'b0, '0, '0);
        nrst = 1'b0;
        checkReset("rst_traffic");
        step(2);
        nrst = 1'b1;
        waitClear("clear_len_traffic");
        readCheck("rst_0x20", 8'h20, 32'h0);

        // Reset after 100 clear cycles must restart from address 0
        applyStimulus(1'b0, 8'h00, '0, 1'b1, 8'h20, 32'hCAFE0001);
        step(1);
        readCheck("preload2_0x20", 8'h20, 32'hCAFE0001);
        applyStimulus(1'b1, 8'h00, '0, 1'b0, '0, '0);
        nrst = 1'b0;
        step(2);
        nrst = 1'b1;
        step(100);
        checkOutput("mid_clear_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        checkReset("rst_clear");
        step(2);
        nrst = 1'b1;
        waitClear("clear_len_restart");
        readCheck("rst2_0x20", 8'h20, 32'h0);

        // Saturating write counter
        for (int i = 1; i <= 65540; i++) begin
            applyStimulus(1'b1, 8'h60, 32'(i), 1'b0, '0, '0);
            step(1);
            if (i == 65534) checkOutput("sat_minus1", 32'(wr_count), 32'h0000FFFE);
        end
        checkOutput("sat_count", 32'(wr_count), 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h61, 32'(32'h80000000 + i), 1'b0, '0, '0);
            step(1);
        end
        checkOutput("sat_stay", 32'(wr_count), 32'h0000FFFF);
        readCheck("sat_last_0x60", 8'h60, 32'd65540);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
